kf8237_transfer_timing_control: RTL and testbench

DMA transfer-cycle sequencer for the KF8237 core. It sits directly upstream of the address/count register bank and drives it through `transfer_register_select`, `next_word` and `initialize_current_register`. It consumes `underflow` and `update_high_address` from that bank. It runs the classic SI/S0/S1/S2/S3/S4 state machine, generates the system bus strobes, HRQ, DACK and EOP, and handles single, block, demand and cascade modes.

---
 rtl/kf8237_common_pkg.sv | 30 +++
 rtl/kf8237_bus_strobe_decode.sv | 56 +++++
 rtl/kf8237_transfer_timing_control.sv | 157 +++++++++++++++
 tb/tb_kf8237_transfer_timing_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf8237_common_pkg.sv
// Shared state encoding and mode/type constants for the KF8237 transfer sequencer.
// Consumers honour the optional KF8237_READY_WAIT_EN build macro (SW wait states).
package kf8237_common_pkg;

  typedef enum logic [2:0] {
    ST_SI = 3'd0,
    ST_S0 = 3'd1,
    ST_S1 = 3'd2,
    ST_S2 = 3'd3,
    ST_S3 = 3'd4,
    ST_SW = 3'd5,
    ST_S4 = 3'd6,
    ST_SC = 3'd7
  } dma_state_e;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  localparam logic [1:0] TYPE_VERIFY = 2'b00;
  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;

  // States in which the DMA controller owns the address bus.
  function automatic logic is_addr_phase(input dma_state_e s);
    return (s == ST_S1) || (s == ST_S2) || (s == ST_S3) || (s == ST_SW) || (s == ST_S4);
  endfunction

endpackage

// File: rtl/kf8237_bus_strobe_decode.sv
// Combinational map from sequencer state and transfer type to the four
// active-low bus strobes; verify and reserved types leave all strobes idle.
module kf8237_bus_strobe_decode
  import kf8237_common_pkg::*;
(
  input  dma_state_e state_i,
  input  logic [1:0] transfer_type_i,
  output logic       memory_read_n_o,
  output logic       memory_write_n_o,
  output logic       io_read_n_o,
  output logic       io_write_n_o
);

  logic read_phase;
  logic write_phase;

  always_comb begin
    read_phase  = 1'b0;
    write_phase = 1'b0;
    case (state_i)
      ST_S2: read_phase = 1'b1;
      ST_S3, ST_SW, ST_S4: begin
        read_phase  = 1'b1;
        write_phase = 1'b1;
      end
      default: begin
        read_phase  = 1'b0;
        write_phase = 1'b0;
      end
    endcase
  end

  always_comb begin
    memory_read_n_o  = 1'b1;
    memory_write_n_o = 1'b1;
    io_read_n_o      = 1'b1;
    io_write_n_o     = 1'b1;
    case (transfer_type_i)
      TYPE_WRITE: begin
        io_read_n_o      = ~read_phase;
        memory_write_n_o = ~write_phase;
      end
      TYPE_READ: begin
        memory_read_n_o = ~read_phase;
        io_write_n_o    = ~write_phase;
      end
      default: begin
        memory_read_n_o  = 1'b1;
        memory_write_n_o = 1'b1;
        io_read_n_o      = 1'b1;
        io_write_n_o     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/kf8237_transfer_timing_control.sv
// KF8237 DMA transfer-cycle sequencer: SI/S0/S1-S4/SW/SC FSM with registered bus outputs.
// Define KF8237_READY_WAIT_EN to add the ready input and SW wait states after S3.
module kf8237_transfer_timing_control
  import kf8237_common_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic       master_clear,
  input  logic [3:0] dma_request_channel,
  input  logic [3:0] dma_request,
  input  logic       hold_acknowledge,
  input  logic [1:0] transfer_mode,
  input  logic [1:0] transfer_type,
  input  logic       autoinitialize,
  input  logic       external_end_of_process,
`ifdef KF8237_READY_WAIT_EN
  input  logic       ready,
`endif
  input  logic       underflow,
  input  logic       update_high_address,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic [3:0] transfer_register_select,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       end_of_process
);

  dma_state_e state_q, state_d;
  logic [3:0] chan_q, chan_d;
  logic       init_d;
  logic       hrq_d, aen_d, adstb_d, nw_d, eop_d;
  logic [3:0] dack_d;
  logic       mrd_n_d, mwr_n_d, iord_n_d, iowr_n_d;
  logic       sel_req;
  logic       tc_eop;
  logic       xfer_done;

  // The register bank does its own commit on the DMA falling edge.
  logic unused_negedge;
  assign unused_negedge = cpu_clock_negedge;

  assign sel_req   = |(dma_request & chan_q);
  assign tc_eop    = underflow | external_end_of_process;
  assign xfer_done = tc_eop || (transfer_mode == MODE_SINGLE) ||
                     ((transfer_mode == MODE_DEMAND) && !sel_req);

  // Next-state logic; the latched channel survives one clock into SI for the init pulse.
  always_comb begin
    state_d = state_q;
    chan_d  = (state_q == ST_SI) ? 4'b0000 : chan_q;
    init_d  = 1'b0;
    if (cpu_clock_posedge) begin
      case (state_q)
        ST_SI: begin
          if (dma_request_channel != 4'b0000) state_d = ST_S0;
          else                                state_d = ST_SI;
        end
        ST_S0: begin
          if (hold_acknowledge) begin
            chan_d  = dma_request_channel;
            state_d = (transfer_mode == MODE_CASCADE) ? ST_SC : ST_S1;
          end else begin
            state_d = ST_S0;
          end
        end
        ST_S1: state_d = ST_S2;
        ST_S2: state_d = ST_S3;
`ifdef KF8237_READY_WAIT_EN
        ST_S3: state_d = ready ? ST_S4 : ST_SW;
        ST_SW: state_d = ready ? ST_S4 : ST_SW;
`else
        ST_S3: state_d = ST_S4;
        ST_SW: state_d = ST_S4;
`endif
        ST_S4: begin
          if (xfer_done) begin
            state_d = ST_SI;
            init_d  = tc_eop & autoinitialize;
          end else begin
            state_d = update_high_address ? ST_S1 : ST_S2;
          end
        end
        ST_SC: begin
          if (!sel_req) state_d = ST_SI;
          else          state_d = ST_SC;
        end
        default: state_d = ST_SI;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from the upcoming state so registered outputs align with the state.
  always_comb begin
    hrq_d   = (state_d != ST_SI);
    aen_d   = is_addr_phase(state_d);
    dack_d  = (aen_d || (state_d == ST_SC)) ? chan_d : 4'b0000;
    adstb_d = (state_d == ST_S1);
    nw_d    = (state_d == ST_S4);
    eop_d   = (state_d == ST_S4) && tc_eop;
  end

  kf8237_bus_strobe_decode u_strobe (
    .state_i          (state_d),
    .transfer_type_i  (transfer_type),
    .memory_read_n_o  (mrd_n_d),
    .memory_write_n_o (mwr_n_d),
    .io_read_n_o      (iord_n_d),
    .io_write_n_o     (iowr_n_d)
  );

  // State and output registers; reset and master clear both abort to idle.
  always_ff @(posedge clock) begin
    if (reset || master_clear) begin
      state_q                     <= ST_SI;
      chan_q                      <= 4'b0000;
      hold_request                <= 1'b0;
      dma_acknowledge             <= 4'b0000;
      next_word                   <= 1'b0;
      initialize_current_register <= 1'b0;
      address_enable              <= 1'b0;
      address_strobe              <= 1'b0;
      end_of_process              <= 1'b0;
      memory_read_n               <= 1'b1;
      memory_write_n              <= 1'b1;
      io_read_n                   <= 1'b1;
      io_write_n                  <= 1'b1;
    end else begin
      state_q                     <= state_d;
      chan_q                      <= chan_d;
      hold_request                <= hrq_d;
      dma_acknowledge             <= dack_d;
      next_word                   <= nw_d;
      initialize_current_register <= init_d;
      address_enable              <= aen_d;
      address_strobe              <= adstb_d;
      end_of_process              <= eop_d;
      memory_read_n               <= mrd_n_d;
      memory_write_n              <= mwr_n_d;
      io_read_n                   <= iord_n_d;
      io_write_n                  <= iowr_n_d;
    end
  end

  assign transfer_register_select = chan_q;

endmodule

// File: tb/tb_kf8237_transfer_timing_control.sv
// Randomized self-checking bench: each transfer is planned as a list of expected
// DMA-clock phases, and outputs are compared against rules for each phase.
module tb_kf8237_transfer_timing_control;

  localparam int P_SI = 0, P_S0 = 1, P_S1 = 2, P_S2 = 3, P_S3 = 4, P_SW = 5, P_S4 = 6, P_SC = 7;
  localparam logic [1:0] M_DEMAND = 2'b00, M_SINGLE = 2'b01, M_BLOCK = 2'b10, M_CASCADE = 2'b11;

  typedef struct {
    int ph;
    bit hl;
    bit uf;
    bit ext;
    bit drop;
    bit uha;
    bit rdy;
  } step_t;

  logic       clock = 1'b0;
  logic       reset, cpu_clock_posedge, cpu_clock_negedge, master_clear;
  logic [3:0] dma_request_channel, dma_request;
  logic       hold_acknowledge;
  logic [1:0] transfer_mode, transfer_type;
  logic       autoinitialize, external_end_of_process, underflow, update_high_address;
`ifdef KF8237_READY_WAIT_EN
  logic       ready;
`endif
  logic       hold_request, next_word, initialize_current_register;
  logic [3:0] dma_acknowledge, transfer_register_select;
  logic       address_enable, address_strobe, end_of_process;
  logic       memory_read_n, memory_write_n, io_read_n, io_write_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  kf8237_transfer_timing_control dut (
    .clock                       (clock),
    .reset                       (reset),
    .cpu_clock_posedge           (cpu_clock_posedge),
    .cpu_clock_negedge           (cpu_clock_negedge),
    .master_clear                (master_clear),
    .dma_request_channel         (dma_request_channel),
    .dma_request                 (dma_request),
    .hold_acknowledge            (hold_acknowledge),
    .transfer_mode               (transfer_mode),
    .transfer_type               (transfer_type),
    .autoinitialize              (autoinitialize),
    .external_end_of_process     (external_end_of_process),
`ifdef KF8237_READY_WAIT_EN
    .ready                       (ready),
`endif
    .underflow                   (underflow),
    .update_high_address         (update_high_address),
    .hold_request                (hold_request),
    .dma_acknowledge             (dma_acknowledge),
    .transfer_register_select    (transfer_register_select),
    .next_word                   (next_word),
    .initialize_current_register (initialize_current_register),
    .address_enable              (address_enable),
    .address_strobe              (address_strobe),
    .memory_read_n               (memory_read_n),
    .memory_write_n              (memory_write_n),
    .io_read_n                   (io_read_n),
    .io_write_n                  (io_write_n),
    .end_of_process              (end_of_process)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {hold_request, dma_acknowledge, address_enable, address_strobe, next_word,
            memory_read_n, memory_write_n, io_read_n, io_write_n};
  endfunction

  // Bus outputs required while the sequencer sits in phase ph.
  function automatic logic [11:0] exp_vec(input int ph, input logic [3:0] ch, input logic [1:0] ty);
    logic hrq, aen, ads, nw, rd, wr;
    logic [3:0] dk;
    hrq = (ph != P_SI);
    aen = (ph == P_S1) || (ph == P_S2) || (ph == P_S3) || (ph == P_SW) || (ph == P_S4);
    dk  = (aen || ph == P_SC) ? ch : 4'b0000;
    ads = (ph == P_S1);
    nw  = (ph == P_S4);
    rd  = (ph == P_S2) || (ph == P_S3) || (ph == P_SW) || (ph == P_S4);
    wr  = (ph == P_S3) || (ph == P_SW) || (ph == P_S4);
    return {hrq, dk, aen, ads, nw,
            !(ty == 2'b10 && rd), !(ty == 2'b01 && wr), !(ty == 2'b01 && rd), !(ty == 2'b10 && wr)};
  endfunction

  function automatic step_t mk(input int ph, input bit hl, input bit rdy);
    step_t s;
    s.ph = ph; s.hl = hl; s.uf = 1'b0; s.ext = 1'b0; s.drop = 1'b0; s.uha = 1'b0; s.rdy = rdy;
    return s;
  endfunction

  // One DMA rising edge; returns #1 after the clock edge that sampled it.
  task automatic edge_tick();
    @(negedge clock);
    cpu_clock_posedge = 1'b1;
    @(posedge clock);
    #1;
    cpu_clock_posedge = 1'b0;
  endtask

  task automatic finish_tick();
    @(negedge clock);
    cpu_clock_negedge = 1'b1;
    @(negedge clock);
    cpu_clock_negedge = 1'b0;
  endtask

  task automatic go_idle_inputs();
    dma_request_channel = 4'b0000; dma_request = 4'b0000; hold_acknowledge = 1'b0;
    underflow = 1'b0; external_end_of_process = 1'b0; update_high_address = 1'b0;
`ifdef KF8237_READY_WAIT_EN
    ready = 1'b1;
`endif
  endtask

  // endk: 0 underflow, 1 external EOP, 2 DREQ drop, 3 underflow with DREQ drop, 4 none.
  task automatic run_xfer(input logic [3:0] ch, input logic [1:0] mode, input logic [1:0] ty,
                          input bit ai, input int nwords, input int endk,
                          input logic [3:0] xmask, input bit abort);
    step_t q[$];
    step_t s;
    int d, wt;
    bit last, term, tc_prev;
    d = $urandom_range(0, 2);
    for (int i = 0; i <= d; i++) q.push_back(mk(P_S0, i == d, 1'b1));
    if (mode == M_CASCADE) begin
      for (int i = 0; i < nwords; i++) begin
        s = mk(P_SC, 1'b1, 1'b1);
        s.drop = (i == nwords - 1);
        q.push_back(s);
      end
    end else begin
      for (int w = 0; w < nwords; w++) begin
        last = (w == nwords - 1);
        if (w == 0 || xmask[w]) q.push_back(mk(P_S1, 1'b1, 1'b1));
        q.push_back(mk(P_S2, 1'b1, 1'b1));
        wt = 0;
`ifdef KF8237_READY_WAIT_EN
        wt = $urandom_range(0, 2);
`endif
        q.push_back(mk(P_S3, 1'b1, wt == 0));
        for (int j = 0; j < wt; j++) q.push_back(mk(P_SW, 1'b1, j == wt - 1));
        s = mk(P_S4, 1'b1, 1'b1);
        if (last) begin
          s.uf   = (endk == 0) || (endk == 3);
          s.ext  = (endk == 1);
          s.drop = (endk == 2) || (endk == 3);
          s.uha  = 1'($urandom);
        end else begin
          s.uha = xmask[w + 1];
        end
        q.push_back(s);
      end
    end
    q.push_back(mk(P_SI, 1'b0, 1'b1));

    transfer_mode = mode; transfer_type = ty; autoinitialize = ai;
    dma_request_channel = ch;
    dma_request = ch | 4'($urandom);
    hold_acknowledge = 1'b0;
    tc_prev = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      s = q[k];
      edge_tick();
      check_eq($sformatf("bus k%0d ph%0d", k, s.ph), 32'(obs_vec()), 32'(exp_vec(s.ph, ch, ty)));
      check_eq($sformatf("trs k%0d ph%0d", k, s.ph), 32'(transfer_register_select),
               32'((s.ph == P_S0) ? 4'b0000 : ch));
      check_eq($sformatf("init k%0d", k), 32'(initialize_current_register),
               32'((s.ph == P_SI) && ai && tc_prev));
      if (abort && s.ph == P_S3) begin
        master_clear = 1'b1;
        @(posedge clock);
        #1;
        master_clear = 1'b0;
        go_idle_inputs();
        check_eq("abort bus", 32'(obs_vec()), 32'(exp_vec(P_SI, ch, ty)));
        check_eq("abort trs", 32'(transfer_register_select), 32'd0);
        check_eq("abort init_eop", 32'({initialize_current_register, end_of_process}), 32'd0);
        finish_tick();
        for (int i = 0; i < 2; i++) begin
          edge_tick();
          check_eq("after abort bus", 32'(obs_vec()), 32'(exp_vec(P_SI, ch, ty)));
          finish_tick();
        end
        return;
      end
      term = (k + 1 < q.size()) && (q[k + 1].ph == P_SI);
      hold_acknowledge        = s.hl;
      underflow               = s.uf;
      external_end_of_process = s.ext;
      update_high_address     = s.uha;
`ifdef KF8237_READY_WAIT_EN
      ready = s.rdy;
`endif
      if (mode == M_DEMAND || mode == M_CASCADE)
        dma_request = s.drop ? (4'($urandom) & ~ch) : (ch | 4'($urandom));
      else
        dma_request = 4'($urandom);
      if (s.ph == P_S0)            dma_request_channel = ch;
      else if (s.ph == P_SI || term) dma_request_channel = 4'b0000;
      else                         dma_request_channel = 4'($urandom);
      @(posedge clock);
      #1;
      check_eq($sformatf("eop k%0d ph%0d", k, s.ph), 32'(end_of_process),
               32'((s.ph == P_S4) && (s.uf || s.ext)));
      check_eq($sformatf("init clr k%0d", k), 32'(initialize_current_register), 32'd0);
      if (s.ph == P_SI) check_eq("trs clr", 32'(transfer_register_select), 32'd0);
      tc_prev = (s.ph == P_S4) && (s.uf || s.ext);
      finish_tick();
    end
    go_idle_inputs();
  endtask

  initial begin
    logic [3:0] ch;
    logic [1:0] mode;
    int n, endk;
    reset = 1'b1; master_clear = 1'b0; cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0;
    transfer_mode = 2'b00; transfer_type = 2'b00; autoinitialize = 1'b0;
    go_idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset bus", 32'(obs_vec()), 32'(exp_vec(P_SI, 4'b0000, 2'b01)));
    check_eq("reset misc", 32'({transfer_register_select, initialize_current_register, end_of_process}), 32'd0);
    reset = 1'b0;
    finish_tick();

    run_xfer(4'b0100, M_SINGLE, 2'b01, 1'b0, 1, 4, 4'b0000, 1'b0);
    run_xfer(4'b0001, M_BLOCK, 2'b10, 1'b0, 3, 0, 4'b0000, 1'b0);
    run_xfer(4'b0001, M_BLOCK, 2'b10, 1'b1, 3, 0, 4'b0000, 1'b0);
    run_xfer(4'b0010, M_DEMAND, 2'b01, 1'b0, 3, 2, 4'b0100, 1'b0);
    run_xfer(4'b0010, M_BLOCK, 2'b01, 1'b0, 2, 0, 4'b0000, 1'b1);
    run_xfer(4'b1000, M_CASCADE, 2'b00, 1'b0, 3, 0, 4'b0000, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ch   = 4'b0001 << $urandom_range(0, 3);
      mode = 2'($urandom);
      n    = (mode == M_SINGLE) ? 1 : $urandom_range(1, 4);
      case (mode)
        M_DEMAND: endk = $urandom_range(0, 3);
        M_BLOCK:  endk = $urandom_range(0, 1);
        M_SINGLE: endk = ($urandom_range(0, 1) == 0) ? 4 : $urandom_range(0, 1);
        default:  endk = 0;
      endcase
      run_xfer(ch, mode, 2'($urandom), 1'($urandom), n, endk, 4'($urandom),
               (mode != M_CASCADE) && ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
